// File: rtl/alu_rs.sv
// alu_rs: reservation station and issue scheduler for the single alu instance.
// Latency: an op with both operands valid issues 2 edges after dispatch; a CDB wakeup adds 1 edge.
// Backpressure: rs_full_out stalls dispatch; alu_full_in and rdy=0 block issue. Define ALU_RS_BYPASS_EN for same-cycle CDB capture at dispatch.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear_flag_in,
  input  logic             dsp_enable_in,
  input  logic [3:0]       dsp_calc_code_in,
  input  logic             dsp_lhs_valid_in,
  input  logic             dsp_rhs_valid_in,
  input  logic [31:0]      dsp_lhs_in,
  input  logic [31:0]      dsp_rhs_in,
  input  logic [TAG_W-1:0] dsp_lhs_tag_in,
  input  logic [TAG_W-1:0] dsp_rhs_tag_in,
  input  logic [TAG_W-1:0] dsp_pos_in_iq_in,
  output logic             rs_full_out,
  input  logic             cdb_enable_in,
  input  logic [TAG_W-1:0] cdb_tag_in,
  input  logic [31:0]      cdb_value_in,
  input  logic             alu_full_in,
  output logic             calc_enable_out,
  output logic [3:0]       calc_code_out,
  output logic [31:0]      lhs_out,
  output logic [31:0]      rhs_out,
  output logic [TAG_W-1:0] pos_in_iq_out
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] lhs_vld;
  logic [RS_SIZE-1:0] rhs_vld;
  logic [3:0]         code    [RS_SIZE];
  logic [31:0]        lhs_val [RS_SIZE];
  logic [31:0]        rhs_val [RS_SIZE];
  logic [TAG_W-1:0]   lhs_tag [RS_SIZE];
  logic [TAG_W-1:0]   rhs_tag [RS_SIZE];
  logic [TAG_W-1:0]   pos     [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic               do_dsp;
  logic               do_issue;
  logic               dsp_lhs_vld;
  logic               dsp_rhs_vld;
  logic [31:0]        dsp_lhs_dat;
  logic [31:0]        dsp_rhs_dat;

  assign rs_full_out = &busy;
  assign ready       = busy & lhs_vld & rhs_vld;
  assign do_dsp      = dsp_enable_in & ~rs_full_out;
  assign do_issue    = sel_found & ~alu_full_in;

  // Lowest-index free slot and lowest-index ready slot, both on pre-edge state
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      if (ready[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Operand values written at dispatch, optionally captured from a same-cycle broadcast
  always_comb begin
    dsp_lhs_vld = dsp_lhs_valid_in;
    dsp_rhs_vld = dsp_rhs_valid_in;
    dsp_lhs_dat = dsp_lhs_in;
    dsp_rhs_dat = dsp_rhs_in;
`ifdef ALU_RS_BYPASS_EN
    if (!dsp_lhs_valid_in && cdb_enable_in && (cdb_tag_in == dsp_lhs_tag_in)) begin
      dsp_lhs_vld = 1'b1;
      dsp_lhs_dat = cdb_value_in;
    end
    if (!dsp_rhs_valid_in && cdb_enable_in && (cdb_tag_in == dsp_rhs_tag_in)) begin
      dsp_rhs_vld = 1'b1;
      dsp_rhs_dat = cdb_value_in;
    end
`endif
  end

  // Entry storage: flush, CDB wakeup, issue release and dispatch write (disjoint entries)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= '0;
      lhs_vld <= '0;
      rhs_vld <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        code[i]    <= '0;
        lhs_val[i] <= '0;
        rhs_val[i] <= '0;
        lhs_tag[i] <= '0;
        rhs_tag[i] <= '0;
        pos[i]     <= '0;
      end
    end else if (rdy) begin
      if (clear_flag_in) begin
        busy <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (cdb_enable_in && busy[i] && !lhs_vld[i] && (lhs_tag[i] == cdb_tag_in)) begin
            lhs_vld[i] <= 1'b1;
            lhs_val[i] <= cdb_value_in;
          end
          if (cdb_enable_in && busy[i] && !rhs_vld[i] && (rhs_tag[i] == cdb_tag_in)) begin
            rhs_vld[i] <= 1'b1;
            rhs_val[i] <= cdb_value_in;
          end
        end
        if (do_issue) busy[sel_idx] <= 1'b0;
        if (do_dsp) begin
          busy[free_idx]    <= 1'b1;
          code[free_idx]    <= dsp_calc_code_in;
          lhs_vld[free_idx] <= dsp_lhs_vld;
          rhs_vld[free_idx] <= dsp_rhs_vld;
          lhs_val[free_idx] <= dsp_lhs_dat;
          rhs_val[free_idx] <= dsp_rhs_dat;
          lhs_tag[free_idx] <= dsp_lhs_tag_in;
          rhs_tag[free_idx] <= dsp_rhs_tag_in;
          pos[free_idx]     <= dsp_pos_in_iq_in;
        end
      end
    end
  end

  // Registered issue port: one-cycle enable pulse, data holds between issues
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      calc_enable_out <= 1'b0;
      calc_code_out   <= '0;
      lhs_out         <= '0;
      rhs_out         <= '0;
      pos_in_iq_out   <= '0;
    end else if (!rdy || clear_flag_in) begin
      calc_enable_out <= 1'b0;
    end else begin
      calc_enable_out <= do_issue;
      if (do_issue) begin
        calc_code_out <= code[sel_idx];
        lhs_out       <= lhs_val[sel_idx];
        rhs_out       <= rhs_val[sel_idx];
        pos_in_iq_out <= pos[sel_idx];
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus randomized traffic.
// A slot-level reference model predicts each issue; a monitor compares on every calc_enable_out.
// Flush, full, bypass and mid-operation reset are exercised.
module tb_alu_rs;
  localparam int RS = 8;

  logic        clk = 1'b0;
  logic        rst, rdy, clear_flag_in, dsp_enable_in;
  logic [3:0]  dsp_calc_code_in;
  logic        dsp_lhs_valid_in, dsp_rhs_valid_in;
  logic [31:0] dsp_lhs_in, dsp_rhs_in;
  logic [4:0]  dsp_lhs_tag_in, dsp_rhs_tag_in, dsp_pos_in_iq_in;
  logic        rs_full_out;
  logic        cdb_enable_in;
  logic [4:0]  cdb_tag_in;
  logic [31:0] cdb_value_in;
  logic        alu_full_in;
  logic        calc_enable_out;
  logic [3:0]  calc_code_out;
  logic [31:0] lhs_out, rhs_out;
  logic [4:0]  pos_in_iq_out;

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  alu_rs #(.RS_SIZE(RS), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_flag_in(clear_flag_in),
    .dsp_enable_in(dsp_enable_in), .dsp_calc_code_in(dsp_calc_code_in),
    .dsp_lhs_valid_in(dsp_lhs_valid_in), .dsp_rhs_valid_in(dsp_rhs_valid_in),
    .dsp_lhs_in(dsp_lhs_in), .dsp_rhs_in(dsp_rhs_in),
    .dsp_lhs_tag_in(dsp_lhs_tag_in), .dsp_rhs_tag_in(dsp_rhs_tag_in),
    .dsp_pos_in_iq_in(dsp_pos_in_iq_in), .rs_full_out(rs_full_out),
    .cdb_enable_in(cdb_enable_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .alu_full_in(alu_full_in), .calc_enable_out(calc_enable_out),
    .calc_code_out(calc_code_out), .lhs_out(lhs_out), .rhs_out(rhs_out),
    .pos_in_iq_out(pos_in_iq_out)
  );

  typedef struct {
    bit          busy;
    logic [3:0]  code;
    logic [31:0] lv, rv;
    bit          lok, rok;
    logic [4:0]  lt, rt, pos;
  } ent_t;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] l;
    logic [31:0] r;
    logic [4:0]  pos;
  } iss_t;

  ent_t m[RS];
  ent_t pre[RS];
  iss_t expq[$];

  task automatic chk(string nm, logic [72:0] got, logic [72:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int n_busy();
    int n = 0;
    for (int i = 0; i < RS; i++) if (m[i].busy) n++;
    return n;
  endfunction

  // Reference behaviour for one rising edge
  task automatic model_step();
    int sel;
    int fr;
    int cnt;
    iss_t e;
    if (!rst) begin
      for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
      expq.delete();
    end else if (rdy) begin
      if (clear_flag_in) begin
        for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
      end else begin
        pre = m;
        sel = -1;
        fr  = -1;
        cnt = 0;
        for (int i = 0; i < RS; i++) begin
          if (pre[i].busy) cnt++;
          if (sel < 0 && pre[i].busy && pre[i].lok && pre[i].rok) sel = i;
          if (fr < 0 && !pre[i].busy) fr = i;
        end
        if (sel >= 0 && !alu_full_in) begin
          e.code = pre[sel].code; e.l = pre[sel].lv; e.r = pre[sel].rv; e.pos = pre[sel].pos;
          expq.push_back(e);
          m[sel].busy = 1'b0;
        end
        if (cdb_enable_in) begin
          for (int i = 0; i < RS; i++) begin
            if (pre[i].busy && !pre[i].lok && pre[i].lt == cdb_tag_in) begin
              m[i].lok = 1'b1; m[i].lv = cdb_value_in;
            end
            if (pre[i].busy && !pre[i].rok && pre[i].rt == cdb_tag_in) begin
              m[i].rok = 1'b1; m[i].rv = cdb_value_in;
            end
          end
        end
        if (dsp_enable_in && cnt < RS) begin
          m[fr].busy = 1'b1;
          m[fr].code = dsp_calc_code_in;
          m[fr].lok = dsp_lhs_valid_in; m[fr].lv = dsp_lhs_in; m[fr].lt = dsp_lhs_tag_in;
          m[fr].rok = dsp_rhs_valid_in; m[fr].rv = dsp_rhs_in; m[fr].rt = dsp_rhs_tag_in;
          m[fr].pos = dsp_pos_in_iq_in;
`ifdef ALU_RS_BYPASS_EN
          if (!dsp_lhs_valid_in && cdb_enable_in && dsp_lhs_tag_in == cdb_tag_in) begin
            m[fr].lok = 1'b1; m[fr].lv = cdb_value_in;
          end
          if (!dsp_rhs_valid_in && cdb_enable_in && dsp_rhs_tag_in == cdb_tag_in) begin
            m[fr].rok = 1'b1; m[fr].rv = cdb_value_in;
          end
`endif
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  // Monitor: compare issue port and full flag against the model every cycle
  initial forever begin
    iss_t g, e;
    @(negedge clk);
    if (rst && mon_on) begin
      chk("rs_full", 73'(rs_full_out), 73'(n_busy() == RS));
      g.code = calc_code_out; g.l = lhs_out; g.r = rhs_out; g.pos = pos_in_iq_out;
      if (calc_enable_out) begin
        if (expq.size() == 0) begin
          chk("unexpected_issue", 73'(g), 73'(0));
          if (g == 0) begin
            fails++;
            $display("FAIL unexpected_issue: issue seen with no expected op at %0t", $time);
          end
        end else begin
          e = expq.pop_front();
          chk("issue", 73'(g), 73'(e));
        end
      end else if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("missing_issue", 73'(calc_enable_out), 73'(1));
      end
    end
  end

  task automatic idle();
    dsp_enable_in = 0; cdb_enable_in = 0; clear_flag_in = 0;
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic dsp(input logic [3:0] c, input bit lv, input logic [31:0] l, input logic [4:0] lt,
                     input bit rv, input logic [31:0] r, input logic [4:0] rt, input logic [4:0] p);
    dsp_enable_in = 1; dsp_calc_code_in = c;
    dsp_lhs_valid_in = lv; dsp_lhs_in = l; dsp_lhs_tag_in = lt;
    dsp_rhs_valid_in = rv; dsp_rhs_in = r; dsp_rhs_tag_in = rt;
    dsp_pos_in_iq_in = p;
  endtask

  task automatic cdb(input logic [4:0] t, input logic [31:0] v);
    cdb_enable_in = 1; cdb_tag_in = t; cdb_value_in = v;
  endtask

  initial begin
    bit hit;
    rst = 1; rdy = 1; alu_full_in = 0; idle();
    dsp(0, 0, 0, 0, 0, 0, 0, 0); dsp_enable_in = 0;
    cdb_tag_in = 0; cdb_value_in = 0;
    #1 rst = 0;
    #1;
    chk("rst_calc_en", 73'(calc_enable_out), 73'(0));
    chk("rst_code", 73'(calc_code_out), 73'(0));
    chk("rst_lhs", 73'(lhs_out), 73'(0));
    chk("rst_rhs", 73'(rhs_out), 73'(0));
    chk("rst_pos", 73'(pos_in_iq_out), 73'(0));
    chk("rst_full", 73'(rs_full_out), 73'(0));
    tick(2);
    rst = 1; mon_on = 1;
    tick();

    // Basic issue latency: two edges after dispatch
    dsp(0, 1, 5, 0, 1, 7, 0, 3); tick(); idle();
    chk("t1_not_yet", 73'(calc_enable_out), 73'(0));
    tick();
    chk("t1_en", 73'(calc_enable_out), 73'(1));
    chk("t1_lhs", 73'(lhs_out), 73'(5));
    chk("t1_rhs", 73'(rhs_out), 73'(7));
    chk("t1_pos", 73'(pos_in_iq_out), 73'(3));
    tick();
    chk("t1_pulse", 73'(calc_enable_out), 73'(0));
    tick(2);

    // Wakeup from CDB three cycles later
    dsp(1, 0, 0, 4, 1, 2, 0, 9); tick(); idle();
    tick(2);
    cdb(4, 32'h10); tick(); idle();
    chk("t2_wait", 73'(calc_enable_out), 73'(0));
    tick();
    chk("t2_en", 73'(calc_enable_out), 73'(1));
    chk("t2_lhs", 73'(lhs_out), 73'(32'h10));
    tick(2);

    // Fill while ALU is full, drop the 9th, then drain in index order
    alu_full_in = 1;
    for (int i = 0; i < 9; i++) begin
      dsp(4'(i), 1, 32'(i * 3), 0, 1, 32'(i + 100), 0, 5'(i)); tick();
    end
    idle();
    chk("t3_full", 73'(rs_full_out), 73'(1));
    alu_full_in = 0;
    tick(11);

    // Same-cycle dispatch and broadcast on tag 6
    dsp(2, 0, 0, 6, 1, 1, 0, 12); cdb(6, 32'h99); tick(); idle();
    tick(4);
    clear_flag_in = 1; tick(); idle();

    // Flush four busy entries, then dispatch again
    alu_full_in = 1;
    for (int i = 0; i < 4; i++) begin
      dsp(4'(i + 5), 1, 32'(i), 0, 1, 32'(i), 0, 5'(20 + i)); tick();
    end
    idle();
    clear_flag_in = 1; tick(); idle();
    alu_full_in = 0;
    tick(3);
    chk("t5_full", 73'(rs_full_out), 73'(0));
    dsp(7, 1, 32'hab, 0, 1, 32'hcd, 0, 30); tick(); idle();
    tick(3);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      alu_full_in = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) clear_flag_in = 1;
      if ($urandom_range(0, 1) == 1)
        dsp(4'($urandom), ($urandom_range(0, 9) < 6), $urandom, 5'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 6), $urandom, 5'($urandom_range(0, 7)), 5'($urandom));
      if (rdy && $urandom_range(0, 9) < 4) cdb(5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    idle(); rdy = 1; alu_full_in = 0;
    tick(12);
    clear_flag_in = 1; tick(); idle();
    tick(2);

    // Reset while issuing
    alu_full_in = 1;
    for (int i = 0; i < 4; i++) begin
      dsp(4'(i), 1, 32'(i + 1), 0, 1, 32'(i + 2), 0, 5'(i + 1)); tick();
    end
    idle(); alu_full_in = 0;
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(posedge clk); #2;
      if (calc_enable_out) hit = 1;
    end
    chk("t6_issuing", 73'(hit), 73'(1));
    rst = 0;
    #1;
    chk("t6_calc_en", 73'(calc_enable_out), 73'(0));
    chk("t6_code", 73'(calc_code_out), 73'(0));
    chk("t6_lhs", 73'(lhs_out), 73'(0));
    chk("t6_rhs", 73'(rhs_out), 73'(0));
    chk("t6_pos", 73'(pos_in_iq_out), 73'(0));
    chk("t6_full", 73'(rs_full_out), 73'(0));
    tick();
    rst = 1;
    tick(4);
    chk("drain", 73'(expq.size()), 73'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
